// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared state encoding and saturating add for score_keeper
package score_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_SHOW   = 2'd3
   } state_t;

   // One extra carry bit keeps the sum exact before it is clamped to max_val.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
   endfunction

endpackage

// File: rtl/hiscore_table.sv
// rtl/hiscore_table.sv - per-map high-score register file, one write port, one registered read port
module hiscore_table #(
   parameter int MAP_W    = 2,
   parameter int POINTS_W = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_we,
   input  logic [MAP_W-1:0]    i_waddr,
   input  logic [POINTS_W-1:0] i_wdata,
   input  logic [MAP_W-1:0]    i_raddr,
   output logic [POINTS_W-1:0] o_rdata
);

   localparam int DEPTH = 1 << MAP_W;

   logic [POINTS_W-1:0] r_mem [DEPTH];
   logic [POINTS_W-1:0] r_rdata;

   // A same-cycle write is forwarded so the new entry appears on the next cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdata <= '0;
      end else begin
         if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
         end
         r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - round counter, saturating point accumulator and high-score commit FSM
module score_keeper
   import score_pkg::*;
#(
   parameter int LEVEL_W   = 2,
   parameter int MAP_W     = 2,
   parameter int ROUND_W   = 4,
   parameter int POINTS_W  = 8,
   parameter int MAX_ROUND = 15
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                START,
   input  logic [LEVEL_W-1:0]  REG_SetupLEVEL,
   input  logic [MAP_W-1:0]    REG_SetupMAPA,
   input  logic                ROUND_OK,
   input  logic                GAME_OVER,
   output logic [ROUND_W-1:0]  ROUND,
   output logic [POINTS_W-1:0] POINTS,
   output logic [POINTS_W-1:0] HIGH_SCORE,
   output logic                NEW_RECORD,
   output logic                WIN,
   output logic                BUSY,
   output logic                DONE
);

   localparam logic [31:0]         PTS_MAX    = (32'd1 << POINTS_W) - 32'd1;
   localparam logic [ROUND_W-1:0]  ROUND_LAST = ROUND_W'(MAX_ROUND);

   state_t              r_state;
   logic [LEVEL_W-1:0]  r_lvl;
   logic [MAP_W-1:0]    r_map;
   logic [ROUND_W-1:0]  r_round;
   logic [POINTS_W-1:0] r_points;
   logic                r_new_record;
   logic                r_win;
   logic                r_busy;
   logic                r_done;

   logic [POINTS_W-1:0] w_points_next;
   logic [ROUND_W-1:0]  w_round_next;
   logic [MAP_W-1:0]    w_rd_addr;
   logic [POINTS_W-1:0] w_hs;
   logic                w_beat;
   logic                w_we;

   assign w_points_next = POINTS_W'(sat_add(32'(r_points), 32'(r_lvl) + 32'd1, PTS_MAX));
   assign w_round_next  = r_round + 1'b1;

   // The read port tracks the live map selector only while idle; otherwise the
   // latched map, so in COMMIT w_hs already holds the stored record for r_map.
   assign w_rd_addr = (r_state == ST_IDLE) ? REG_SetupMAPA : r_map;
   assign w_beat    = (r_points > w_hs);
   assign w_we      = (r_state == ST_COMMIT) && w_beat;

   hiscore_table #(
      .MAP_W    (MAP_W),
      .POINTS_W (POINTS_W)
   ) u_table (
      .i_clk   (CLOCK),
      .i_rst   (RESET),
      .i_we    (w_we),
      .i_waddr (r_map),
      .i_wdata (r_points),
      .i_raddr (w_rd_addr),
      .o_rdata (w_hs)
   );

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state      <= ST_IDLE;
         r_lvl        <= '0;
         r_map        <= '0;
         r_round      <= '0;
         r_points     <= '0;
         r_new_record <= 1'b0;
         r_win        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_SHOW: begin
               if (START) begin
                  r_lvl        <= REG_SetupLEVEL;
                  r_map        <= REG_SetupMAPA;
                  r_round      <= '0;
                  r_points     <= '0;
                  r_new_record <= 1'b0;
                  r_win        <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (GAME_OVER) begin
                  r_win   <= 1'b0;
                  r_state <= ST_COMMIT;
               end else if (ROUND_OK) begin
                  r_round  <= w_round_next;
                  r_points <= w_points_next;
                  if (w_round_next == ROUND_LAST) begin
                     r_win   <= 1'b1;
                     r_state <= ST_COMMIT;
                  end
               end
            end
            ST_COMMIT: begin
               r_new_record <= w_beat;
               r_busy       <= 1'b0;
               r_done       <= 1'b1;
               r_state      <= ST_SHOW;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ROUND      = r_round;
   assign POINTS     = r_points;
   assign HIGH_SCORE = w_hs;
   assign NEW_RECORD = r_new_record;
   assign WIN        = r_win;
   assign BUSY       = r_busy;
   assign DONE       = r_done;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Parametrised, clocked successor to the combinational level*round score logic of the Genius game. It counts completed rounds and accumulates points at (level+1) per round, with saturation. On game end it commits the score to a per-map high-score table and flags new records. It sits between the game-control FSM, which supplies round/end events, and the display path, which shows POINTS, ROUND and HIGH_SCORE.

Parameters:
LEVEL_W, 2, width of REG_SetupLEVEL; multiplier = LEVEL+1, range 1..2^LEVEL_W.
MAP_W, 2, width of REG_SetupMAPA; high-score table depth = 2^MAP_W.
ROUND_W, 4, width of the round counter.
POINTS_W, 8, width of POINTS and HIGH_SCORE.
MAX_ROUND, 15, round count that ends the game as a win; must be 1..2^ROUND_W-1.

Ports:
CLOCK  in  1  system clock, rising edge.
RESET  in  1  synchronous, active-high reset.
START  in  1  one-cycle pulse; begins a new game.
REG_SetupLEVEL  in  LEVEL_W  difficulty level; sampled on START.
REG_SetupMAPA  in  MAP_W  map select; sampled on START; live-selects HIGH_SCORE in IDLE.
ROUND_OK  in  1  one-cycle pulse; player completed the current round.
GAME_OVER  in  1  one-cycle pulse; player failed.
ROUND  out  ROUND_W  rounds completed in the current game.
POINTS  out  POINTS_W  accumulated score.
HIGH_SCORE  out  POINTS_W  high-score entry for the selected map.
NEW_RECORD  out  1  high when the last committed game beat the stored record.
WIN  out  1  high when the last game ended by reaching MAX_ROUND.
BUSY  out  1  high in PLAY and COMMIT.
DONE  out  1  one-cycle pulse when the commit completes.

Behaviour:
- The clock is CLOCK. RESET is synchronous and active-high; all state updates on the rising edge of CLOCK.
- Reset: state=IDLE. ROUND, POINTS, NEW_RECORD, WIN, BUSY, DONE = 0. Every high-score table entry = 0. HIGH_SCORE = 0 on the first cycle after reset.
- FSM states: IDLE, PLAY, COMMIT, SHOW.
- IDLE, START=1:
  - latch lvl=REG_SetupLEVEL and map=REG_SetupMAPA;
  - clear ROUND, POINTS, NEW_RECORD, WIN;
  - go to PLAY.
- PLAY (BUSY=1):
  - GAME_OVER=1: go to COMMIT, WIN=0. GAME_OVER has priority; a simultaneous ROUND_OK is ignored.
  - else ROUND_OK=1: ROUND<=ROUND+1 and POINTS<=min(POINTS+lvl+1, 2^POINTS_W-1). Both update in the same cycle, so POINTS and ROUND are valid one cycle after the pulse. If the new ROUND equals MAX_ROUND, go to COMMIT with WIN=1.
  - START in PLAY is ignored. Changes on REG_SetupLEVEL and REG_SetupMAPA have no effect.
- COMMIT (BUSY=1, exactly one cycle):
  - if POINTS > table[map] (strictly greater), write table[map]<=POINTS and set NEW_RECORD=1;
  - a tie does not update and leaves NEW_RECORD=0;
  - go to SHOW with DONE=1 for that one cycle.
- SHOW (BUSY=0): hold ROUND, POINTS, NEW_RECORD and WIN. START behaves exactly as START in IDLE.
- HIGH_SCORE is registered with one cycle of latency:
  - in IDLE it shows table[REG_SetupMAPA];
  - otherwise it shows table[map];
  - after COMMIT it reflects the updated entry in the first SHOW cycle.
- Arithmetic: the add is done at POINTS_W+1 bits, then clamped. POINTS never wraps. ROUND cannot wrap because MAX_ROUND terminates the game.
- RESET in any state, including mid-game or during COMMIT, returns to the reset values and clears the table. No partial commit is made.
- Invariant: POINTS == min((lvl+1)*ROUND, 2^POINTS_W-1) at all times.

Decomposition:
- A shared package score_pkg holds the state encoding (IDLE=0, PLAY=1, COMMIT=2, SHOW=3) and the saturating-add helper function.
- One sub-module, hiscore_table: 2^MAP_W x POINTS_W register file with synchronous reset-clear, one write port and one registered read port.

Test Plan:
1. Reset, then START with level=2, map=1, then 4 ROUND_OK pulses spaced 2 cycles apart, then GAME_OVER -> ROUND=4, POINTS=12, DONE pulses once, HIGH_SCORE=12, NEW_RECORD=1, WIN=0.
2. Second game on map 1, level=0, 5 rounds, then GAME_OVER -> POINTS=5, NEW_RECORD=0, HIGH_SCORE stays 12. A third game scoring exactly 12 -> no update, NEW_RECORD=0.
3. Level=3 with 15 ROUND_OK pulses (defaults) -> POINTS=60, ROUND=15, automatic COMMIT, WIN=1, DONE without any GAME_OVER.
4. POINTS_W=5, level=3, 15 rounds -> POINTS clamps at 31 from round 8 onward and never wraps; table stores 31.
5. ROUND_OK and GAME_OVER in the same cycle at ROUND=3 -> ROUND stays 3. Changing REG_SetupLEVEL and REG_SetupMAPA mid-game leaves the increment and the commit map unchanged.
6. RESET asserted in PLAY at ROUND=6 -> all outputs 0, table cleared. In IDLE, stepping REG_SetupMAPA 0..3 shows HIGH_SCORE=0 for each entry, one cycle after each change.
